ps2_frame_rx: RTL and testbench

//  Receives PS/2 keyboard frames on the system clock. Syncs and glitch-filters ps2_clk, shifts the 11-bit frame
//  (start, 8 data LSB-first, odd parity, stop) and checks it. Folds E0/F0 prefixes into flags on the final key code.

---
 rtl/ps2_frame_rx.sv | 160 ++++++++++++++++
 tb/tb_ps2_frame_rx.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_frame_rx.sv
// PS/2 keyboard frame receiver: synchronises and glitch-filters the PS/2 clock, shifts and checks
// 11-bit frames, and folds E0/F0 prefix bytes into flags on the final key code.
module ps2_frame_rx #(
    parameter int unsigned FILTER_LEN  = 8,
    parameter int unsigned TIMEOUT_CYC = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] raw_byte,
    output logic       raw_valid,
    output logic [7:0] code,
    output logic       code_valid,
    output logic       is_ext,
    output logic       is_break,
    output logic       frame_err,
    output logic [1:0] err_code
);

    localparam int unsigned FW = $clog2(FILTER_LEN);
    localparam int unsigned TW = $clog2(TIMEOUT_CYC);
    localparam logic [FW-1:0] FLT_MAX = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT_CYC - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RECV  = 2'd1;
    localparam logic [1:0] CHECK = 2'd2;

    logic          clk_s1, clk_s2, dat_s1, dat_s2;
    logic          clk_f;
    logic [FW-1:0] flt_cnt;
    logic          fall;

    logic [1:0]    state;
    logic [3:0]    bitcnt;
    logic [TW-1:0] to_cnt;
    logic [7:0]    shreg;
    logic          par_b;
    logic          stop_b;
    logic          ext_pend;
    logic          brk_pend;

    // Filtered clock only flips after FILTER_LEN consecutive disagreeing samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_s1  <= 1'b1;
            clk_s2  <= 1'b1;
            dat_s1  <= 1'b1;
            dat_s2  <= 1'b1;
            clk_f   <= 1'b1;
            flt_cnt <= '0;
            fall    <= 1'b0;
        end else begin
            clk_s1 <= ps2_clk;
            clk_s2 <= clk_s1;
            dat_s1 <= ps2_data;
            dat_s2 <= dat_s1;
            fall   <= 1'b0;
            if (clk_s2 == clk_f) begin
                flt_cnt <= '0;
            end else if (flt_cnt == FLT_MAX) begin
                clk_f   <= clk_s2;
                flt_cnt <= '0;
                fall    <= clk_f;
            end else begin
                flt_cnt <= flt_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            bitcnt     <= '0;
            to_cnt     <= '0;
            shreg      <= '0;
            par_b      <= 1'b0;
            stop_b     <= 1'b0;
            ext_pend   <= 1'b0;
            brk_pend   <= 1'b0;
            raw_byte   <= '0;
            raw_valid  <= 1'b0;
            code       <= '0;
            code_valid <= 1'b0;
            is_ext     <= 1'b0;
            is_break   <= 1'b0;
            frame_err  <= 1'b0;
            err_code   <= '0;
        end else begin
            raw_valid  <= 1'b0;
            code_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                IDLE: begin
                    to_cnt <= '0;
                    if (fall && !dat_s2) begin
                        state  <= RECV;
                        bitcnt <= '0;
                    end
                end
                RECV: begin
                    // A fall coinciding with timeout wins and keeps the frame alive.
                    if (fall) begin
                        to_cnt <= '0;
                        bitcnt <= bitcnt + 1'b1;
                        if (bitcnt < 4'd8) begin
                            shreg[bitcnt[2:0]] <= dat_s2;
                        end else if (bitcnt == 4'd8) begin
                            par_b <= dat_s2;
                        end else begin
                            stop_b <= dat_s2;
                            state  <= CHECK;
                        end
                    end else if (to_cnt == TO_MAX) begin
                        state     <= IDLE;
                        frame_err <= 1'b1;
                        err_code  <= 2'b11;
                        ext_pend  <= 1'b0;
                        brk_pend  <= 1'b0;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                CHECK: begin
                    state  <= IDLE;
                    to_cnt <= '0;
                    if (!stop_b) begin
                        frame_err <= 1'b1;
                        err_code  <= 2'b10;
                        ext_pend  <= 1'b0;
                        brk_pend  <= 1'b0;
                    end else if (!(^{shreg, par_b})) begin
                        frame_err <= 1'b1;
                        err_code  <= 2'b01;
                        ext_pend  <= 1'b0;
                        brk_pend  <= 1'b0;
                    end else begin
                        raw_valid <= 1'b1;
                        raw_byte  <= shreg;
                        if (shreg == 8'hE0) begin
                            ext_pend <= 1'b1;
                        end else if (shreg == 8'hF0) begin
                            brk_pend <= 1'b1;
                        end else begin
                            code_valid <= 1'b1;
                            code       <= shreg;
                            is_ext     <= ext_pend;
                            is_break   <= brk_pend;
                            ext_pend   <= 1'b0;
                            brk_pend   <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_frame_rx.sv
// Directed bench for ps2_frame_rx: drives 80-cycle PS/2 bit periods with a short timeout
// and checks strobes, prefix folding, error codes, glitch rejection and reset behaviour.
module tb_ps2_frame_rx;

    localparam int unsigned FLEN = 8;
    localparam int unsigned TOUT = 200;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] raw_byte;
    logic       raw_valid;
    logic [7:0] code;
    logic       code_valid;
    logic       is_ext;
    logic       is_break;
    logic       frame_err;
    logic [1:0] err_code;

    ps2_frame_rx #(.FILTER_LEN(FLEN), .TIMEOUT_CYC(TOUT)) dut (
        .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .raw_byte(raw_byte), .raw_valid(raw_valid), .code(code), .code_valid(code_valid),
        .is_ext(is_ext), .is_break(is_break), .frame_err(frame_err), .err_code(err_code)
    );

    always #500 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    int         n_raw = 0, n_code = 0, n_err = 0, n_consec = 0;
    logic [7:0] raw_q[$];
    logic [7:0] l_code = '0;
    logic       l_ext = 1'b0, l_brk = 1'b0;
    logic [1:0] l_err = '0;
    logic       prev_strobe = 1'b0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (raw_valid) begin n_raw++; raw_q.push_back(raw_byte); end
            if (code_valid) begin n_code++; l_code = code; l_ext = is_ext; l_brk = is_break; end
            if (frame_err) begin n_err++; l_err = err_code; end
            if ((raw_valid || code_valid || frame_err) && prev_strobe) n_consec++;
            prev_strobe = raw_valid || code_valid || frame_err;
        end else begin
            prev_strobe = 1'b0;
        end
    end

    task automatic cyc(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    // Each bit: data changes mid-high, 40 cycles low, 40 cycles high.
    task automatic send_frame(input logic [7:0] b, input logic par_flip, input logic stop_v,
                              input int unsigned nbits);
        logic [10:0] f;
        f = {stop_v, (~^b) ^ par_flip, b, 1'b0};
        for (int unsigned i = 0; i < nbits; i++) begin
            ps2_data = f[i];
            cyc(20);
            ps2_clk = 1'b0;
            cyc(40);
            ps2_clk = 1'b1;
            cyc(20);
        end
        ps2_data = 1'b1;
    endtask

    task automatic good(input logic [7:0] b);
        send_frame(b, 1'b0, 1'b1, 11);
        cyc(60);
    endtask

    task automatic test_reset;
        logic [22:0] outs;
        outs = {raw_byte, raw_valid, code, code_valid, is_ext, is_break, frame_err, err_code};
        tests_run++;
        if (outs !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %h expected 0", outs);
        end
    endtask

    task automatic test_single;
        int r0, c0, e0;
        r0 = n_raw; c0 = n_code; e0 = n_err;
        good(8'h16);
        tests_run++;
        if (n_raw - r0 !== 1) begin tests_failed++; $display("FAIL single_raw_cnt: got %0d expected 1", n_raw - r0); end
        tests_run++;
        if (raw_q[r0] !== 8'h16) begin tests_failed++; $display("FAIL single_raw_byte: got %h expected 16", raw_q[r0]); end
        tests_run++;
        if (n_code - c0 !== 1 || l_code !== 8'h16 || l_ext !== 1'b0 || l_brk !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_code: got n=%0d code=%h ext=%b brk=%b expected n=1 code=16 ext=0 brk=0",
                     n_code - c0, l_code, l_ext, l_brk);
        end
        tests_run++;
        if (n_err !== e0) begin tests_failed++; $display("FAIL single_no_err: got %0d errors expected 0", n_err - e0); end
        tests_run++;
        if (code !== 8'h16 || raw_byte !== 8'h16) begin
            tests_failed++; $display("FAIL single_hold: got code=%h raw=%h expected 16/16", code, raw_byte);
        end
    endtask

    task automatic test_break;
        int r0, c0;
        r0 = n_raw; c0 = n_code;
        good(8'hF0);
        good(8'h16);
        tests_run++;
        if (n_raw - r0 !== 2 || raw_q[r0] !== 8'hF0 || raw_q[r0 + 1] !== 8'h16) begin
            tests_failed++; $display("FAIL break_raw: got n=%0d expected n=2 bytes F0,16", n_raw - r0);
        end
        tests_run++;
        if (n_code - c0 !== 1 || l_code !== 8'h16 || l_brk !== 1'b1 || l_ext !== 1'b0) begin
            tests_failed++;
            $display("FAIL break_code: got n=%0d code=%h ext=%b brk=%b expected n=1 code=16 ext=0 brk=1",
                     n_code - c0, l_code, l_ext, l_brk);
        end
        good(8'h16);
        tests_run++;
        if (l_brk !== 1'b0 || is_break !== 1'b0) begin
            tests_failed++; $display("FAIL break_cleared: got brk=%b expected 0", l_brk);
        end
    endtask

    task automatic test_ext_break;
        int r0, c0;
        r0 = n_raw; c0 = n_code;
        good(8'hE0);
        good(8'hF0);
        good(8'h75);
        tests_run++;
        if (n_raw - r0 !== 3) begin tests_failed++; $display("FAIL ext_raw_cnt: got %0d expected 3", n_raw - r0); end
        tests_run++;
        if (n_code - c0 !== 1 || l_code !== 8'h75 || l_ext !== 1'b1 || l_brk !== 1'b1) begin
            tests_failed++;
            $display("FAIL ext_code: got n=%0d code=%h ext=%b brk=%b expected n=1 code=75 ext=1 brk=1",
                     n_code - c0, l_code, l_ext, l_brk);
        end
    endtask

    task automatic test_parity;
        int r0, c0, e0;
        r0 = n_raw; c0 = n_code; e0 = n_err;
        send_frame(8'h1E, 1'b1, 1'b1, 11);
        cyc(60);
        tests_run++;
        if (n_err - e0 !== 1 || l_err !== 2'b01) begin
            tests_failed++; $display("FAIL parity_err: got n=%0d err=%b expected n=1 err=01", n_err - e0, l_err);
        end
        tests_run++;
        if (n_raw !== r0 || n_code !== c0) begin
            tests_failed++; $display("FAIL parity_no_valid: got raw=%0d code=%0d expected 0/0", n_raw - r0, n_code - c0);
        end
        good(8'hF0);
        send_frame(8'h1E, 1'b1, 1'b1, 11);
        cyc(60);
        good(8'h1E);
        tests_run++;
        if (l_code !== 8'h1E || l_brk !== 1'b0) begin
            tests_failed++; $display("FAIL parity_clears_pend: got code=%h brk=%b expected 1E/0", l_code, l_brk);
        end
        tests_run++;
        if (err_code !== 2'b01) begin
            tests_failed++; $display("FAIL err_code_hold: got %b expected 01", err_code);
        end
    endtask

    task automatic test_stop;
        int r0, e0;
        r0 = n_raw; e0 = n_err;
        send_frame(8'h45, 1'b0, 1'b0, 11);
        cyc(60);
        tests_run++;
        if (n_err - e0 !== 1 || l_err !== 2'b10 || n_raw !== r0) begin
            tests_failed++;
            $display("FAIL stop_err: got n=%0d err=%b raw=%0d expected n=1 err=10 raw=0", n_err - e0, l_err, n_raw - r0);
        end
        send_frame(8'h45, 1'b1, 1'b0, 11);
        cyc(60);
        tests_run++;
        if (n_err - e0 !== 2 || l_err !== 2'b10) begin
            tests_failed++; $display("FAIL stop_over_parity: got n=%0d err=%b expected n=2 err=10", n_err - e0, l_err);
        end
    endtask

    task automatic test_timeout;
        int unsigned k;
        logic        seen;
        seen = 1'b0;
        k = 60;
        send_frame(8'h16, 1'b0, 1'b1, 5);
        while (!seen && k < 600) begin
            @(negedge clk);
            k++;
            if (frame_err) seen = 1'b1;
        end
        tests_run++;
        if (!seen || err_code !== 2'b11) begin
            tests_failed++; $display("FAIL timeout_err: got seen=%b err=%b expected seen=1 err=11", seen, err_code);
        end
        tests_run++;
        if (k < TOUT + FLEN + 1 || k > TOUT + FLEN + 5) begin
            tests_failed++; $display("FAIL timeout_latency: got %0d cycles expected %0d..%0d", k, TOUT + FLEN + 1, TOUT + FLEN + 5);
        end
        cyc(40);
    endtask

    task automatic test_glitch;
        int r0, c0, e0;
        r0 = n_raw; c0 = n_code; e0 = n_err;
        ps2_data = 1'b0;
        cyc(10);
        ps2_clk = 1'b0;
        cyc(3);
        ps2_clk = 1'b1;
        cyc(10);
        ps2_data = 1'b1;
        cyc(TOUT + 100);
        tests_run++;
        if (n_err !== e0 || n_raw !== r0) begin
            tests_failed++; $display("FAIL glitch_ignored: got err=%0d raw=%0d expected 0/0", n_err - e0, n_raw - r0);
        end
        good(8'h45);
        tests_run++;
        if (n_code - c0 !== 1 || l_code !== 8'h45 || n_err !== e0) begin
            tests_failed++;
            $display("FAIL glitch_next_frame: got n=%0d code=%h err=%0d expected n=1 code=45 err=0", n_code - c0, l_code, n_err - e0);
        end
    endtask

    task automatic test_reset_mid;
        logic [22:0] outs;
        int c0, e0;
        send_frame(8'h3C, 1'b0, 1'b1, 5);
        rst_n = 1'b0;
        cyc(3);
        outs = {raw_byte, raw_valid, code, code_valid, is_ext, is_break, frame_err, err_code};
        tests_run++;
        if (outs !== '0) begin
            tests_failed++; $display("FAIL reset_mid_outputs: got %h expected 0", outs);
        end
        rst_n = 1'b1;
        cyc(20);
        c0 = n_code; e0 = n_err;
        good(8'h16);
        tests_run++;
        if (n_code - c0 !== 1 || l_code !== 8'h16 || n_err !== e0 || l_ext !== 1'b0 || l_brk !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid_next: got n=%0d code=%h err=%0d ext=%b brk=%b expected n=1 code=16 err=0 ext=0 brk=0",
                     n_code - c0, l_code, n_err - e0, l_ext, l_brk);
        end
    endtask

    task automatic test_back_to_back;
        int r0, c0;
        r0 = n_raw; c0 = n_code;
        send_frame(8'h1C, 1'b0, 1'b1, 11);
        send_frame(8'h32, 1'b0, 1'b1, 11);
        cyc(60);
        tests_run++;
        if (n_code - c0 !== 2 || n_raw - r0 !== 2 || raw_q[r0] !== 8'h1C || l_code !== 8'h32) begin
            tests_failed++;
            $display("FAIL back_to_back: got n=%0d first=%h last=%h expected n=2 first=1C last=32", n_code - c0, raw_q[r0], l_code);
        end
        tests_run++;
        if (n_consec !== 0) begin
            tests_failed++; $display("FAIL strobe_spacing: got %0d consecutive strobes expected 0", n_consec);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        cyc(5);
        test_reset;
        rst_n = 1'b1;
        cyc(20);
        test_single;
        test_break;
        test_ext_break;
        test_parity;
        test_stop;
        test_timeout;
        test_glitch;
        test_reset_mid;
        test_back_to_back;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
